// File: rtl/sw_debouncer.sv
// ---------------------------------------------------------------------------
// sw_debouncer
//   Conditions the board slide switches before they reach the shiftleds stage.
//   Each raw switch bit goes through a 2-FF synchronizer and then a per-bit
//   debounce counter. A new level is published on o_sw only after the
//   synchronized input has disagreed with o_sw for DEBOUNCE_LIMIT consecutive
//   clocks. Registered one-cycle rise/fall/change strobes accompany each
//   accepted transition.
//
// Parameters
//   NB_SW          number of switch bits
//   NB_COUNT       width of each per-bit debounce counter
//   DEBOUNCE_LIMIT consecutive mismatching clocks needed to accept a level
//                  (1 <= DEBOUNCE_LIMIT <= 2**NB_COUNT)
//
// Ports
//   clock        system clock, rising-edge active
//   i_reset      asynchronous active-low reset
//   i_sw         raw, asynchronous, bouncing switch inputs
//   o_sw         debounced stable switch value (registered)
//   o_sw_rise    per-bit one-cycle pulse on an accepted 0->1 transition
//   o_sw_fall    per-bit one-cycle pulse on an accepted 1->0 transition
//   o_sw_change  one-cycle pulse when any bit is accepted in that cycle
// ---------------------------------------------------------------------------
module sw_debouncer #(
    parameter int unsigned NB_SW          = 4,
    parameter int unsigned NB_COUNT       = 14,
    parameter int unsigned DEBOUNCE_LIMIT = 10000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall,
    output logic             o_sw_change
);

    // Terminal count; DEBOUNCE_LIMIT = 2**NB_COUNT still fits once reduced by one.
    localparam logic [NB_COUNT-1:0] LIMIT_M1 = NB_COUNT'(DEBOUNCE_LIMIT - 1);

    logic [NB_SW-1:0] sync1;
    logic [NB_SW-1:0] sync2;
    logic [NB_SW-1:0] mismatch;
    logic [NB_SW-1:0] commit;

    // Two-stage synchronizer, no logic between the stages.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
        end
    end

    assign mismatch = sync2 ^ o_sw;

    // Per-bit counters: any agreement with o_sw restarts the count from zero,
    // and the count also restarts on the cycle a new level is accepted, so it
    // never wraps.
    for (genvar b = 0; b < NB_SW; b++) begin : g_bit
        logic [NB_COUNT-1:0] cnt;

        assign commit[b] = mismatch[b] && (cnt == LIMIT_M1);

        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                cnt <= '0;
            end else if (!mismatch[b] || commit[b]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A committing bit always takes the synchronized level, which is the
    // inverse of its current o_sw value, so a toggle under the commit mask
    // is equivalent to loading sync2 for those bits.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_sw        <= '0;
            o_sw_rise   <= '0;
            o_sw_fall   <= '0;
            o_sw_change <= 1'b0;
        end else begin
            o_sw        <= o_sw ^ commit;
            o_sw_rise   <= commit & sync2;
            o_sw_fall   <= commit & ~sync2;
            o_sw_change <= |commit;
        end
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// ---------------------------------------------------------------------------
// tb_sw_debouncer
//   Scoreboard bench for sw_debouncer with DEBOUNCE_LIMIT = 4. The stimulus
//   process drives i_sw/i_reset once per clock and pushes the expected output
//   for that edge, taken from a history-window model: a bit is accepted when
//   the input sampled two edges earlier has disagreed with the stable value
//   on each of the last LIMIT edges. A monitor pops and compares on every
//   falling edge.
// ---------------------------------------------------------------------------
module tb_sw_debouncer;

    localparam int LIMIT = 4;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic [3:0] o_sw;
    logic [3:0] o_sw_rise;
    logic [3:0] o_sw_fall;
    logic       o_sw_change;

    sw_debouncer #(
        .NB_SW          (4),
        .NB_COUNT       (14),
        .DEBOUNCE_LIMIT (LIMIT)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_sw        (i_sw),
        .o_sw        (o_sw),
        .o_sw_rise   (o_sw_rise),
        .o_sw_fall   (o_sw_fall),
        .o_sw_change (o_sw_change)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] sw;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Model state: accepted value and the recent input samples (hist[0] is
    // the sample taken one edge ago).
    logic [3:0] m_stable;
    logic [3:0] hist[$];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        hist.delete();
        repeat (LIMIT + 1) hist.push_back(4'h0);
    endtask

    task automatic model_edge(input logic [3:0] v, input logic rst);
        exp_t       e;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       all_diff;
        if (!rst) begin
            model_reset();
            e = '0;
        end else begin
            rise = '0;
            fall = '0;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < LIMIT; j++)
                    if (hist[1 + j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    rise[b] = ~m_stable[b];
                    fall[b] = m_stable[b];
                end
            end
            m_stable = m_stable ^ (rise | fall);
            hist.push_front(v);
            void'(hist.pop_back());
            e.sw   = m_stable;
            e.rise = rise;
            e.fall = fall;
            e.chg  = |(rise | fall);
        end
        exp_q.push_back(e);
    endtask

    // One clock: drive, wait for the edge, then record the expected result.
    task automatic step(input logic [3:0] v, input logic rst);
        if (!rst && i_reset) begin
            // Asynchronous assertion clears the outputs before the next sample.
            if (exp_q.size() > 0) exp_q[$] = '0;
            model_reset();
        end
        i_sw    = v;
        i_reset = rst;
        @(posedge clock);
        #1;
        model_edge(v, rst);
    endtask

    task automatic check_cleared(input string tag);
        check4({tag, "_sw"},   o_sw,      4'h0);
        check4({tag, "_rise"}, o_sw_rise, 4'h0);
        check4({tag, "_fall"}, o_sw_fall, 4'h0);
        check4({tag, "_chg"},  {3'b0, o_sw_change}, 4'h0);
    endtask

    // Monitor: every cycle presents an output, compared at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check4("o_sw",        o_sw,      e.sw);
                check4("o_sw_rise",   o_sw_rise, e.rise);
                check4("o_sw_fall",   o_sw_fall, e.fall);
                check4("o_sw_change", {3'b0, o_sw_change}, {3'b0, e.chg});
                checks++;
                if ((o_sw_rise & o_sw_fall) != 4'h0) begin
                    errors++;
                    $display("FAIL rise_fall_overlap: got %h expected 0", o_sw_rise & o_sw_fall);
                end
            end
        end
    end

    initial begin
        logic [3:0]  v;
        int unsigned n;

        i_reset = 1'b1;
        i_sw    = 4'hF;
        model_reset();
        #2;
        i_reset = 1'b0;
        #1;
        check_cleared("reset_async");

        step(4'hF, 1'b0);
        step(4'h0, 1'b0);

        // Clean step to 0101.
        repeat (3) step(4'h0, 1'b1);
        repeat (9) step(4'h5, 1'b1);

        // Back to 0, then bounce bit0 and settle high.
        repeat (9) step(4'h0, 1'b1);
        step(4'h1, 1'b1);
        step(4'h0, 1'b1);
        step(4'h1, 1'b1);
        step(4'h0, 1'b1);
        repeat (9) step(4'h1, 1'b1);

        // Short glitch low on bit0.
        repeat (3) step(4'h0, 1'b1);
        repeat (9) step(4'h1, 1'b1);

        // Simultaneous commits 0011 -> 1100.
        repeat (9) step(4'h3, 1'b1);
        repeat (9) step(4'hC, 1'b1);

        // Reset while stable high.
        repeat (9) step(4'hF, 1'b1);
        @(negedge clock);
        #2;
        if (exp_q.size() > 0) exp_q[$] = '0;
        model_reset();
        i_reset = 1'b0;
        #1;
        check_cleared("reset_mid");
        repeat (2) step(4'hF, 1'b0);
        repeat (9) step(4'hF, 1'b1);

        // Randomized segments with varied hold times and occasional resets.
        for (int s = 0; s < 250; s++) begin
            v = 4'($urandom);
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0)
                repeat ($urandom_range(1, 2)) step(v, 1'b0);
            repeat (n) step(v, 1'b1);
        end
        repeat (8) step(v, 1'b1);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Front-end conditioner for the board slide switches; its `o_sw` drives the `i_sw` input of the shiftleds stage directly.
- Each switch bit passes through a 2-FF synchronizer, then a per-bit debounce counter.
- The stable value is published only after the synchronized input has held a new level for DEBOUNCE_LIMIT consecutive clocks.
- Also emits one-cycle rise/fall/change strobes for downstream control logic.

Parameters:
- NB_SW, 4, number of switch bits (matches the shiftleds NB_SW).
- NB_COUNT, 14, width of each per-bit debounce counter.
- DEBOUNCE_LIMIT, 10000, consecutive stable cycles required to accept a new level.
  - Legal range: 1 ≤ DEBOUNCE_LIMIT ≤ 2^NB_COUNT.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately.
- i_sw  input  NB_SW  raw, asynchronous, bouncing switch inputs.
- o_sw  output  NB_SW  debounced stable switch value (registered).
- o_sw_rise  output  NB_SW  per-bit one-cycle pulse when o_sw bit goes 0→1.
- o_sw_fall  output  NB_SW  per-bit one-cycle pulse when o_sw bit goes 1→0.
- o_sw_change  output  1  one-cycle pulse, OR of all rise/fall bits in the same cycle.

Behaviour:
- Reset (i_reset=0, async):
  - sync1, sync2, o_sw, all counters, o_sw_rise, o_sw_fall and o_sw_change go to 0 immediately.
  - Outputs hold 0 until the first rising edge after deassertion.
  - Deassertion takes effect at the next rising edge (external reset synchronizer owns removal timing).
- Synchronizer: per bit, sync1 <= i_sw, sync2 <= sync1. No logic between the two stages.
- Debounce per bit b, evaluated every rising edge:
  - If sync2[b] == o_sw[b]: cnt[b] <= 0. Rise/fall for b is 0.
  - If sync2[b] != o_sw[b] and cnt[b] < DEBOUNCE_LIMIT-1: cnt[b] <= cnt[b]+1. o_sw unchanged.
  - If sync2[b] != o_sw[b] and cnt[b] == DEBOUNCE_LIMIT-1: o_sw[b] <= sync2[b] and cnt[b] <= 0.
    - o_sw_rise[b] <= sync2[b]; o_sw_fall[b] <= ~sync2[b] (both registered in the same edge).
- Latency: a clean step on i_sw first sampled at edge E appears on o_sw after edge E+1+DEBOUNCE_LIMIT.
  - That is the (DEBOUNCE_LIMIT+2)th rising edge counting E.
  - Rise/fall strobe is high for exactly the one following cycle.
- Glitch rejection: any return of sync2[b] to o_sw[b] before the limit clears cnt[b] to 0. The count restarts from 0 on the next mismatch; there is no partial credit.
- Bit independence: each bit has its own counter. Simultaneous bit transitions may commit in the same cycle; o_sw_change is then one pulse, not several.
- Counter arithmetic:
  - Unsigned, NB_COUNT bits.
  - Compare against DEBOUNCE_LIMIT-1, truncated to NB_COUNT bits.
  - Never wraps, because it clears at the limit.
- DEBOUNCE_LIMIT=1: accept on the first mismatching cycle. Latency is 3 edges.
- Strobes are registered, never combinational. o_sw_rise and o_sw_fall for the same bit are never high together.
- Reset mid-count: counters are discarded; o_sw returns to 0 even if a bit was stable high.
  - After release, a still-high input is re-accepted after the full latency, with a rise pulse.
- Input held constant forever: o_sw constant, counters 0, no strobes.

Test Plan:
- Reset check, DEBOUNCE_LIMIT=4: i_reset=0 with i_sw=4'hF -> o_sw=0, strobes=0, asynchronously (checked before any clock edge).
- Clean step, DEBOUNCE_LIMIT=4: release reset, i_sw 0→4'b0101 at edge E -> o_sw=4'b0101 after edge E+5; o_sw_rise=4'b0101 and o_sw_change=1 for exactly one cycle; o_sw_fall=0.
- Bounce rejection, DEBOUNCE_LIMIT=4: bit0 toggles 1,0,1,0 on successive cycles, then holds 1 -> o_sw[0] stays 0 during toggling; goes 1 exactly 5 edges after the final 0→1 sample; one rise pulse only.
- Short glitch: o_sw=4'b0001, i_sw[0] drops to 0 for 3 cycles (< limit after sync) then returns to 1 -> no fall pulse, o_sw unchanged, cnt[0] back to 0.
- Simultaneous commits: i_sw 4'b0011→4'b1100 in one step -> after the latency, o_sw=4'b1100, o_sw_rise=4'b1100, o_sw_fall=4'b0011 in the same cycle; o_sw_change high one cycle.
- Reset mid-operation: o_sw=4'hF, assert i_reset=0 for 2 cycles with i_sw held at 4'hF -> o_sw=0 immediately; after release, o_sw=4'hF after 6 edges with o_sw_rise=4'hF pulse.
